// File: rtl/display_scan_n.sv
// Multi-digit seven-segment display driver.
// A loaded binary value goes through a sequential double-dabble conversion to BCD.
// The result is time-multiplexed onto shared segment lines, with optional leading-zero
// blanking and a dash pattern when the value does not fit in N_DIGITS digits.
module display_scan_n #(
  parameter int unsigned N_DIGITS         = 4,
  parameter int unsigned IN_WIDTH         = 14,
  parameter int unsigned REFRESH_OVERFLOW = 2**19 - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] value_i,
  input  logic                load_i,
  input  logic                blank_lz_i,
  output logic                busy_o,
  output logic [N_DIGITS-1:0] digit_select,
  output logic [6:0]          led_select
);

  localparam int unsigned BcdW = 4 * N_DIGITS + 4;
  localparam int unsigned NNib = N_DIGITS + 1;
  localparam int unsigned DispW = 4 * N_DIGITS;
  localparam int unsigned CntW = $clog2(IN_WIDTH + 1);
  localparam int unsigned RefW = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CntW-1:0] IterInit = CntW'(IN_WIDTH);
  localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_OVERFLOW);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                sticky_q, sticky_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DispW-1:0]    disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [RefW-1:0]     ref_q, ref_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [BcdW-1:0]     adj;
  logic [3:0]          nibble;
  logic                upper_nz;
  logic [6:0]          seg;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      bin_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      ref_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
    end
  end

  // Converter next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load_i) state_d = StShift;
      StShift:  if (cnt_q == CntW'(1)) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Converter outputs.
  always_comb begin
    busy_o = (state_q != StIdle);
  end

  // Double-dabble correction: every nibble (guard included) >= 5 gets +3 before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(NNib); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Converter datapath; bits pushed out of the guard nibble stick as overflow.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          bin_d    = value_i;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = IterInit;
        end
      end
      StShift: begin
        bcd_d    = {adj[BcdW-2:0], bin_q[IN_WIDTH-1]};
        sticky_d = sticky_q | adj[BcdW-1];
        bin_d    = bin_q << 1;
        cnt_d    = cnt_q - 1'b1;
      end
      StCommit: begin
        disp_d = bcd_q[DispW-1:0];
        ovf_d  = sticky_q | (bcd_q[BcdW-1 -: 4] != 4'd0);
      end
      default: ;
    endcase
  end

  // Free-running refresh counter and digit scan index.
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RefMax) begin
      ref_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Digit decode: anode select, BCD-to-segment, blanking and overflow dashes.
  always_comb begin
    digit_select = ~(N_DIGITS'(1) << idx_q);
    nibble       = disp_q[{idx_q, 2'b00} +: 4];
    upper_nz     = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if ((IdxW'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    unique case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (ovf_q) begin
      led_select = 7'b0111111;
    end else if (blank_lz_i && (idx_q != '0) && !upper_nz) begin
      led_select = 7'b1111111;
    end else begin
      led_select = seg;
    end
  end

endmodule

// File: tb/tb_display_scan_n.sv
// Bench for display_scan_n: behavioural model of conversion timing and display decode,
// randomized loads, plus literal checks of the documented scenarios.
module tb_display_scan_n;

  localparam int N  = 4;
  localparam int IW = 14;
  localparam int RO = 3;
  localparam int Lim = 10 ** N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] value_i = '0;
  logic          load_i = 1'b0;
  logic          blank_lz_i = 1'b0;
  logic          busy_o;
  logic [N-1:0]  digit_select;
  logic [6:0]    led_select;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release, cycles of busy left, pending and shown values.
  int m_ticks = 0;
  int m_busy_left = 0;
  int m_pend = 0;
  int m_disp = 0;

  display_scan_n #(
    .N_DIGITS        (N),
    .IN_WIDTH        (IW),
    .REFRESH_OVERFLOW(RO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_i     (value_i),
    .load_i      (load_i),
    .blank_lz_i  (blank_lz_i),
    .busy_o      (busy_o),
    .digit_select(digit_select),
    .led_select  (led_select)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(input int val, input int idx, input logic blank);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (val >= Lim) return 7'b0111111;
    if (blank && idx > 0 && val < p) return 7'b1111111;
    return seg_of((val / p) % 10);
  endfunction

  function automatic logic [N-1:0] exp_sel(input int idx);
    logic [N-1:0] s;
    s = '1;
    s[idx] = 1'b0;
    return s;
  endfunction

  // Per-cycle compare against the model, then advance the model by the upcoming clock edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_rst", 32'(busy_o), 32'(0));
      check("sel_rst", 32'(digit_select), 32'(exp_sel(0)));
      check("led_rst", 32'(led_select), 32'(exp_led(0, 0, blank_lz_i)));
      m_ticks     <= 0;
      m_busy_left <= 0;
      m_disp      <= 0;
    end else begin
      check("busy", 32'(busy_o), 32'(m_busy_left > 0));
      check("sel", 32'(digit_select), 32'(exp_sel((m_ticks / (RO + 1)) % N)));
      check("led", 32'(led_select),
            32'(exp_led(m_disp, (m_ticks / (RO + 1)) % N, blank_lz_i)));
      m_ticks <= m_ticks + 1;
      if (m_busy_left > 0) begin
        m_busy_left <= m_busy_left - 1;
        if (m_busy_left == 1) m_disp <= m_pend;
      end else if (load_i) begin
        m_busy_left <= IW + 1;
        m_pend      <= int'(value_i);
      end
    end
  end

  task automatic do_load(input int v);
    @(posedge clk); #1;
    value_i = v[IW-1:0];
    load_i  = 1'b1;
    @(posedge clk); #1;
    load_i  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy_o) return;
    end
    check(name, 32'(busy_o), 32'(0));
  endtask

  // Wait for digit d to be scanned, then compare its segments to a literal.
  task automatic check_digit(input string name, input int d, input logic [6:0] exp);
    for (int c = 0; c < 4 * (RO + 1) * N + 4; c++) begin
      @(negedge clk);
      if (digit_select == exp_sel(d)) begin
        check(name, 32'(led_select), 32'(exp));
        return;
      end
    end
    check({name, "_timeout"}, 32'(digit_select), 32'(exp_sel(d)));
  endtask

  initial begin
    int busy_cnt;
    int rv;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("lit_sel0", 32'(digit_select), 32'(4'b1110));
    check("lit_led0", 32'(led_select), 32'(7'b1000000));
    check_digit("lit_zero_d1", 1, 7'b1000000);
    check_digit("lit_zero_d3", 3, 7'b1000000);
    @(posedge clk); #1 blank_lz_i = 1'b1;
    check_digit("lit_blank_d2", 2, 7'b1111111);
    check_digit("lit_blank_d0", 0, 7'b1000000);
    @(posedge clk); #1 blank_lz_i = 1'b0;

    // 1234: busy pulse length, then each digit.
    do_load(1234);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      else break;
    end
    check("lit_busy_len_1234", 32'(busy_cnt), 32'(15));
    check_digit("lit_1234_d3", 3, 7'b1111001);
    check_digit("lit_1234_d2", 2, 7'b0100100);
    check_digit("lit_1234_d1", 1, 7'b0110000);
    check_digit("lit_1234_d0", 0, 7'b0011001);

    // 9999 fits, 10000 overflows.
    do_load(9999);
    wait_idle("idle_9999");
    check_digit("lit_9999_d3", 3, 7'b0010000);
    check_digit("lit_9999_d0", 0, 7'b0010000);
    do_load(10000);
    wait_idle("idle_10000");
    check_digit("lit_ovf_d3", 3, 7'b0111111);
    check_digit("lit_ovf_d1", 1, 7'b0111111);
    @(posedge clk); #1 blank_lz_i = 1'b1;
    check_digit("lit_ovf_blank_d2", 2, 7'b0111111);

    // 42 with blanking, then without.
    do_load(42);
    wait_idle("idle_42");
    check_digit("lit_42_d3", 3, 7'b1111111);
    check_digit("lit_42_d2", 2, 7'b1111111);
    check_digit("lit_42_d1", 1, 7'b0011001);
    check_digit("lit_42_d0", 0, 7'b0100100);
    @(posedge clk); #1 blank_lz_i = 1'b0;
    check_digit("lit_42_nb_d3", 3, 7'b1000000);
    check_digit("lit_42_nb_d2", 2, 7'b1000000);

    // 5678 with an ignored load of 1 during busy.
    do_load(5678);
    busy_cnt = 0;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) begin
        value_i = IW'(1);
        load_i  = 1'b1;
      end
      @(negedge clk);
      if (busy_o) busy_cnt++;
      @(posedge clk); #1;
      load_i = 1'b0;
    end
    check("lit_busy_len_5678", 32'(busy_cnt), 32'(15));
    check_digit("lit_5678_d3", 3, 7'b0010010);
    check_digit("lit_5678_d0", 0, 7'b0000000);

    // Reset in the middle of converting 8888.
    do_load(8888);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("lit_busy_async_rst", 32'(busy_o), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("lit_sel_after_rst", 32'(digit_select), 32'(4'b1110));
    check("lit_led_after_rst", 32'(led_select), 32'(7'b1000000));
    check_digit("lit_rst_d3", 3, 7'b1000000);

    // Randomized loads (some while busy) and blanking toggles.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      load_i = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) rv = int'($urandom_range(0, 99));
      else rv = int'($urandom_range(0, 16383));
      value_i = rv[IW-1:0];
      if ($urandom_range(0, 49) == 0) blank_lz_i = ~blank_lz_i;
    end
    @(posedge clk); #1 load_i = 1'b0;
    wait_idle("idle_final");
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
